ysyx_lsu_axi_bridge: RTL and testbench

Converts the LSU's level-held load/store request interface into single-beat AXI4-Lite transactions on the data-side master port. It sits directly downstream of the LSU and upstream of the data arbiter / crossbar. It handles byte-lane alignment (strobe and data shift by address low bits), misalignment rejection, and returns a one-cycle completion pulse to the LSU.

---
 rtl/ysyx_lsu_axi_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_ysyx_lsu_axi_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_lsu_axi_bridge.sv
// LSU-to-AXI4-Lite bridge: turns the LSU's level-held load/store requests
// into single-beat AXI4-Lite transactions. It shifts data and strobes into the
// addressed byte lanes, rejects misaligned or badly sized accesses without
// touching the bus, and returns a one-cycle completion pulse to the LSU.
module ysyx_lsu_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // LSU load side
    input  logic [ADDR_W-1:0] i_lsu_araddr,
    input  logic              i_lsu_arvalid,
    input  logic [7:0]        i_lsu_rstrb,
    output logic [DATA_W-1:0] o_lsu_rdata,
    output logic              o_lsu_rvalid,
    // LSU store side
    input  logic [ADDR_W-1:0] i_lsu_awaddr,
    input  logic              i_lsu_awvalid,
    input  logic              i_lsu_wvalid,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [7:0]        i_lsu_wstrb,
    output logic              o_lsu_wready,
    output logic              o_lsu_err,
    // AXI4-Lite master
    output logic [ADDR_W-1:0] o_araddr,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [3:0]        o_wstrb,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AWW, S_B, S_RESP} state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_size;
    logic [DATA_W-1:0]  r_wdata;
    logic [3:0]         r_wstrb;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic               r_lsu_rvalid;
    logic               r_lsu_wready;
    logic               r_arvalid;
    logic               r_rready;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_aw_done;
    logic               r_w_done;

    logic               w_ld_ok;
    logic               w_st_ok;
    logic               w_aw_fin;
    logic               w_w_fin;
    logic [DATA_W-1:0]  w_load_mask;
    logic               w_unused;

    // Legal size codes are byte/half/word; half needs addr[0]=0, word addr[1:0]=0.
    function automatic logic size_ok(input logic [3:0] sz, input logic [1:0] lo);
        case (sz)
            4'h1:    size_ok = 1'b1;
            4'h3:    size_ok = ~lo[0];
            4'hf:    size_ok = (lo == 2'b00);
            default: size_ok = 1'b0;
        endcase
    endfunction

    assign w_ld_ok  = size_ok(i_lsu_rstrb[3:0], i_lsu_araddr[1:0]);
    assign w_st_ok  = size_ok(i_lsu_wstrb[3:0], i_lsu_awaddr[1:0]);

    // A channel counts as finished if it already handshook or handshakes now.
    assign w_aw_fin = r_aw_done | (r_awvalid & i_awready);
    assign w_w_fin  = r_w_done  | (r_wvalid  & i_wready);

    // Each size bit selects one byte lane, so the size code doubles as the
    // zero-fill mask for right-aligned load data.
    assign w_load_mask = {{8{r_size[3]}}, {8{r_size[2]}}, {8{r_size[1]}}, {8{r_size[0]}}};

    // Upper size nibbles carry no meaning for this bridge.
    assign w_unused = &{1'b0, i_lsu_rstrb[7:4], i_lsu_wstrb[7:4]};

    assign o_lsu_rdata  = r_rdata;
    assign o_lsu_rvalid = r_lsu_rvalid;
    assign o_lsu_wready = r_lsu_wready;
    assign o_lsu_err    = r_err;
    assign o_araddr     = r_addr;
    assign o_arvalid    = r_arvalid;
    assign o_rready     = r_rready;
    assign o_awaddr     = r_addr;
    assign o_awvalid    = r_awvalid;
    assign o_wdata      = r_wdata;
    assign o_wstrb      = r_wstrb;
    assign o_wvalid     = r_wvalid;
    assign o_bready     = r_bready;

    // Transaction FSM with registered AXI and LSU outputs.
    // NOTE: every register here uses <= so all state moves together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_lsu_rvalid <= 1'b0;
            r_lsu_wready <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle.
            r_lsu_rvalid <= 1'b0;
            r_lsu_wready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_lsu_arvalid) begin
                        r_addr <= i_lsu_araddr;
                        r_size <= i_lsu_rstrb[3:0];
                        if (w_ld_ok) begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end else begin
                            r_rdata      <= '0;
                            r_err        <= 1'b1;
                            r_lsu_rvalid <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end else if (i_lsu_awvalid && i_lsu_wvalid) begin
                        r_addr  <= i_lsu_awaddr;
                        r_size  <= i_lsu_wstrb[3:0];
                        r_wdata <= i_lsu_wdata << {i_lsu_awaddr[1:0], 3'b000};
                        r_wstrb <= i_lsu_wstrb[3:0] << i_lsu_awaddr[1:0];
                        if (w_st_ok) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_AWW;
                        end else begin
                            r_err        <= 1'b1;
                            r_lsu_wready <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_AR: begin
                    if (i_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (i_rvalid) begin
                        r_rready     <= 1'b0;
                        r_rdata      <= (i_rdata >> {r_addr[1:0], 3'b000}) & w_load_mask;
                        r_err        <= (i_rresp != 2'b00);
                        r_lsu_rvalid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_AWW: begin
                    if (r_awvalid && i_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && i_wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end
                end
                S_B: begin
                    if (i_bvalid) begin
                        r_bready     <= 1'b0;
                        r_aw_done    <= 1'b0;
                        r_w_done     <= 1'b0;
                        r_err        <= (i_bresp != 2'b00);
                        r_lsu_wready <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_lsu_axi_bridge.sv
// Self-checking bench for ysyx_lsu_axi_bridge: directed cases then randomized
// loads/stores against a byte-lane reference model and a delay-programmable
// AXI4-Lite slave.
module tb_ysyx_lsu_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_lsu_araddr;
    logic        i_lsu_arvalid;
    logic [7:0]  i_lsu_rstrb;
    logic [31:0] o_lsu_rdata;
    logic        o_lsu_rvalid;
    logic [31:0] i_lsu_awaddr;
    logic        i_lsu_awvalid;
    logic        i_lsu_wvalid;
    logic [31:0] i_lsu_wdata;
    logic [7:0]  i_lsu_wstrb;
    logic        o_lsu_wready;
    logic        o_lsu_err;
    logic [31:0] o_araddr;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] o_awaddr;
    logic        o_awvalid;
    logic        i_awready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        o_wvalid;
    logic        i_wready;
    logic [1:0]  i_bresp;
    logic        i_bvalid;
    logic        o_bready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ysyx_lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_lsu_araddr(i_lsu_araddr), .i_lsu_arvalid(i_lsu_arvalid), .i_lsu_rstrb(i_lsu_rstrb),
        .o_lsu_rdata(o_lsu_rdata), .o_lsu_rvalid(o_lsu_rvalid),
        .i_lsu_awaddr(i_lsu_awaddr), .i_lsu_awvalid(i_lsu_awvalid), .i_lsu_wvalid(i_lsu_wvalid),
        .i_lsu_wdata(i_lsu_wdata), .i_lsu_wstrb(i_lsu_wstrb),
        .o_lsu_wready(o_lsu_wready), .o_lsu_err(o_lsu_err),
        .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int nbytes(input logic [3:0] sz);
        case (sz)
            4'h1:    return 1;
            4'h3:    return 2;
            4'hf:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [3:0] sz);
        int n = nbytes(sz);
        return (n == 0) || ((int'(a[1:0]) % n) != 0);
    endfunction

    function automatic logic [31:0] load_exp(input logic [31:0] word, input logic [31:0] a,
                                             input logic [3:0] sz);
        int n = nbytes(sz);
        longint m;
        if (misaligned(a, sz)) return 32'h0;
        m = (64'd1 << (8 * n)) - 1;
        return (word >> (8 * int'(a[1:0]))) & m[31:0];
    endfunction

    function automatic logic [3:0] strb_exp(input logic [31:0] a, input logic [3:0] sz);
        int n = nbytes(sz);
        int s = ((1 << n) - 1) << int'(a[1:0]);
        return s[3:0];
    endfunction

    task automatic clear_slave();
        i_arready = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0; i_rresp = 2'b00;
        i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_bresp = 2'b00;
    endtask

    // Issue one load, act as slave with programmable waits, check everything.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [3:0] sz,
                           input logic [31:0] word, input logic [1:0] resp,
                           input int ar_d, input int r_d);
        int c = 0, ar_cnt = 0, r_cnt = 0, pulses = 0, pulse_c = -1, first_ar = -1, aw_seen = 0;
        logic [31:0] got_addr = 32'hx;
        logic [31:0] exp_data;
        bit mis;
        mis = misaligned(addr, sz);
        exp_data = load_exp(word, addr, sz);
        i_lsu_araddr  = addr;
        i_lsu_rstrb   = {4'($urandom), sz};
        i_lsu_arvalid = 1'b1;
        while (pulses == 0 && c < 60) begin
            @(posedge clk); #1; c++;
            if (o_awvalid) aw_seen++;
            if (o_arvalid) begin
                if (first_ar < 0) first_ar = c;
                i_arready = (ar_cnt >= ar_d);
                if (i_arready) got_addr = o_araddr;
                ar_cnt++;
            end else i_arready = 1'b0;
            if (o_rready) begin
                i_rvalid = (r_cnt >= r_d); i_rdata = word; i_rresp = resp; r_cnt++;
            end else begin
                i_rvalid = 1'b0; i_rdata = $urandom; i_rresp = 2'b00;
            end
            if (o_lsu_rvalid) begin
                pulses++; pulse_c = c;
                check({tag, "_rdata"}, o_lsu_rdata, exp_data);
                check({tag, "_err"}, 32'(o_lsu_err), 32'(mis || resp != 2'b00));
                check({tag, "_no_wready"}, 32'(o_lsu_wready), 32'd0);
                i_lsu_arvalid = 1'b0;
            end
        end
        @(posedge clk); #1;
        check({tag, "_single_pulse"}, 32'(o_lsu_rvalid), 32'd0);
        check({tag, "_rdata_hold"}, o_lsu_rdata, exp_data);
        check({tag, "_latency"}, 32'(pulse_c), mis ? 32'd1 : 32'(3 + ar_d + r_d));
        check({tag, "_no_store"}, 32'(aw_seen), 32'd0);
        if (mis) check({tag, "_no_ar"}, 32'(ar_cnt), 32'd0);
        else begin
            check({tag, "_ar_first"}, 32'(first_ar), 32'd1);
            check({tag, "_ar_cycles"}, 32'(ar_cnt), 32'(ar_d + 1));
            check({tag, "_araddr"}, got_addr, addr);
        end
    endtask

    // Issue one store with independent AW/W/B waits and check lanes and timing.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [3:0] sz,
                            input logic [31:0] data, input logic [1:0] resp,
                            input int aw_d, input int w_d, input int b_d);
        int c = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, pulses = 0, pulse_c = -1;
        int early_b = 0, ar_seen = 0;
        logic [31:0] got_awaddr = 32'hx, got_wdata = 32'hx;
        logic [3:0]  got_wstrb = 4'hx;
        bit mis;
        mis = misaligned(addr, sz);
        i_lsu_awaddr  = addr;
        i_lsu_wdata   = data;
        i_lsu_wstrb   = {4'($urandom), sz};
        i_lsu_awvalid = 1'b1;
        i_lsu_wvalid  = 1'b1;
        while (pulses == 0 && c < 60) begin
            @(posedge clk); #1; c++;
            if (o_arvalid) ar_seen++;
            if (o_bready && (o_awvalid || o_wvalid)) early_b++;
            if (o_awvalid) begin
                i_awready = (aw_cnt >= aw_d);
                if (i_awready) got_awaddr = o_awaddr;
                aw_cnt++;
            end else i_awready = 1'b0;
            if (o_wvalid) begin
                i_wready = (w_cnt >= w_d);
                if (i_wready) begin got_wdata = o_wdata; got_wstrb = o_wstrb; end
                w_cnt++;
            end else i_wready = 1'b0;
            if (o_bready) begin
                i_bvalid = (b_cnt >= b_d); i_bresp = resp; b_cnt++;
            end else begin
                i_bvalid = 1'b0; i_bresp = 2'b00;
            end
            if (o_lsu_wready) begin
                pulses++; pulse_c = c;
                check({tag, "_err"}, 32'(o_lsu_err), 32'(mis || resp != 2'b00));
                check({tag, "_no_rvalid"}, 32'(o_lsu_rvalid), 32'd0);
                i_lsu_awvalid = 1'b0;
                i_lsu_wvalid  = 1'b0;
            end
        end
        @(posedge clk); #1;
        check({tag, "_single_pulse"}, 32'(o_lsu_wready), 32'd0);
        check({tag, "_no_load"}, 32'(ar_seen), 32'd0);
        if (mis) begin
            check({tag, "_latency"}, 32'(pulse_c), 32'd1);
            check({tag, "_no_bus"}, 32'(aw_cnt + w_cnt), 32'd0);
        end else begin
            check({tag, "_latency"}, 32'(pulse_c),
                  32'(3 + ((aw_d > w_d) ? aw_d : w_d) + b_d));
            check({tag, "_aw_cycles"}, 32'(aw_cnt), 32'(aw_d + 1));
            check({tag, "_w_cycles"}, 32'(w_cnt), 32'(w_d + 1));
            check({tag, "_bready_after_both"}, 32'(early_b), 32'd0);
            check({tag, "_awaddr"}, got_awaddr, addr);
            check({tag, "_wdata"}, got_wdata, data << (8 * int'(addr[1:0])));
            check({tag, "_wstrb"}, 32'(got_wstrb), 32'(strb_exp(addr, sz)));
        end
    endtask

    initial begin
        int guard;
        logic [3:0] sizes [5];
        sizes = '{4'h1, 4'h3, 4'hf, 4'h7, 4'h2};

        // Reset state
        rst = 1'b1;
        i_lsu_araddr = 32'h0; i_lsu_arvalid = 1'b0; i_lsu_rstrb = 8'h0;
        i_lsu_awaddr = 32'h0; i_lsu_awvalid = 1'b0; i_lsu_wvalid = 1'b0;
        i_lsu_wdata = 32'h0; i_lsu_wstrb = 8'h0;
        clear_slave();
        repeat (3) @(posedge clk);
        #2;
        check("rst_outputs", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                              o_lsu_rvalid, o_lsu_wready, o_lsu_err}, 32'd0);
        check("rst_rdata", o_lsu_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed loads
        do_load("lw_aligned", 32'h8000_0004, 4'hf, 32'hDEAD_BEEF, 2'b00, 0, 0);
        do_load("lb_lane3",   32'h8000_0003, 4'h1, 32'h1122_3344, 2'b00, 0, 0);
        do_load("lh_lane2",   32'h8000_0002, 4'h3, 32'h1122_3344, 2'b00, 0, 0);
        do_load("lb_lane1",   32'h8000_0001, 4'h1, 32'h1122_3344, 2'b00, 1, 2);

        // Directed stores
        do_store("sb_lane1", 32'h8000_0001, 4'h1, 32'h0000_00AB, 2'b00, 0, 0, 0);
        do_store("sh_lane2", 32'h8000_0002, 4'h3, 32'h0000_1234, 2'b00, 0, 0, 0);
        do_store("sw_aw_late", 32'h8000_0010, 4'hf, 32'hCAFE_F00D, 2'b00, 3, 0, 1);
        do_store("sw_w_late",  32'h8000_0014, 4'hf, 32'h0BAD_F00D, 2'b00, 0, 2, 0);

        // Error paths
        do_load("lw_misaligned", 32'h8000_0002, 4'hf, 32'h5555_5555, 2'b00, 0, 0);
        do_load("lw_slverr",     32'h8000_0008, 4'hf, 32'h7777_8888, 2'b10, 0, 0);
        do_store("sh_misaligned", 32'h8000_0003, 4'h3, 32'h0000_BEEF, 2'b00, 0, 0, 0);
        do_store("sw_decerr",     32'h8000_0020, 4'hf, 32'h1234_5678, 2'b11, 1, 1, 1);
        do_load("lb_bad_size",   32'h8000_0000, 4'h7, 32'h1111_1111, 2'b00, 0, 0);

        // Simultaneous requests: load first, then the still-held store
        i_lsu_awaddr = 32'h8000_0030; i_lsu_wdata = 32'hA5A5_5A5A; i_lsu_wstrb = 8'h0f;
        i_lsu_awvalid = 1'b1; i_lsu_wvalid = 1'b1;
        do_load("both_load_first", 32'h8000_0034, 4'hf, 32'h0102_0304, 2'b00, 0, 0);
        do_store("both_store_next", 32'h8000_0030, 4'hf, 32'hA5A5_5A5A, 2'b00, 0, 0, 0);

        // Reset while waiting in R aborts with no pulse
        i_lsu_araddr = 32'h8000_0040; i_lsu_rstrb = 8'h0f; i_lsu_arvalid = 1'b1;
        guard = 0;
        while (!o_rready && guard < 10) begin
            @(posedge clk); #1; guard++;
            i_arready = o_arvalid;
        end
        check("rst_mid_reached_r", 32'(o_rready), 32'd1);
        i_arready = 1'b0;
        #2;
        rst = 1'b1; i_lsu_arvalid = 1'b0;
        #1;
        check("rst_mid_async_outs", {o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready,
                                     o_lsu_rvalid, o_lsu_wready, o_lsu_err}, 32'd0);
        check("rst_mid_rdata", o_lsu_rdata, 32'h0);
        i_rvalid = 1'b1; i_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #2;
        check("rst_mid_no_pulse", 32'(o_lsu_rvalid), 32'd0);
        rst = 1'b0; clear_slave();
        @(posedge clk); #1;
        check("rst_mid_idle_after", {o_arvalid, o_rready, o_lsu_rvalid}, 32'd0);
        do_load("after_rst_load", 32'h8000_0044, 4'h3, 32'hBEEF_CAFE, 2'b00, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            logic [3:0]  sz;
            logic [1:0]  rsp;
            a   = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            sz  = sizes[$urandom_range(4, 0)];
            rsp = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            if ($urandom_range(1, 0) == 1)
                do_load("rnd_load", a, sz, $urandom, rsp,
                        int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
            else
                do_store("rnd_store", a, sz, $urandom, rsp, int'($urandom_range(3, 0)),
                         int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
